// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down counter with borrow cascade and optional mm:ss digit.
// Define BCD_TIMER_SATURATE_EN to hold at zero instead of wrapping to all-MAX.
module bcd_down_timer #(
  parameter int unsigned DIGITS = 4,
  parameter bit          MMSS   = 1'b1
) (
  input  logic                  clock,
  input  logic                  clrn,
  input  logic                  loadn,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   data,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  tc,
  output logic                  done,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  // Largest legal value of digit i: the tens-of-seconds digit is mod-6 in mm:ss mode
  function automatic logic [3:0] digit_max(input int unsigned i);
    return (MMSS && (i == 1)) ? 4'd5 : 4'd9;
  endfunction

  logic [W-1:0] dec_count;
  logic [W-1:0] load_count;
  logic [W-1:0] count_nxt;
  logic         clamp_any;
  logic         done_nxt;
  logic         err_nxt;

  assign zero = (count == '0);
  assign tc   = enable && zero;

  // Decrement with ripple borrow; an all-zero count naturally wraps to all-MAX
  always_comb begin : decrement
    logic borrow;
    dec_count = count;
    borrow    = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        dec_count[4*i +: 4] = (count[4*i +: 4] == 4'd0) ? digit_max(i)
                                                        : count[4*i +: 4] - 4'd1;
      end
      borrow = borrow && (count[4*i +: 4] == 4'd0);
    end
  end

  // Clamp out-of-range preset digits to their maximum and flag the event
  always_comb begin : load_clamp
    load_count = data;
    clamp_any  = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (data[4*i +: 4] > digit_max(i)) begin
        load_count[4*i +: 4] = digit_max(i);
        clamp_any            = 1'b1;
      end
    end
  end

  // Counting has priority over loading; load is discarded while enable is high
  always_comb begin : next_state
    count_nxt = count;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (enable) begin
`ifdef BCD_TIMER_SATURATE_EN
      if (!zero) begin
        count_nxt = dec_count;
      end
`else
      count_nxt = dec_count;
`endif
      done_nxt = !zero && (dec_count == '0);
    end else if (!loadn) begin
      count_nxt = load_count;
      err_nxt   = clamp_any;
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      count    <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      done     <= done_nxt;
      load_err <= err_nxt;
    end
  end

endmodule
